// File: rtl/maze_stream_host.sv
// maze_stream_host: transmit-side source and scoreboard for the maze solver.
// Builds a 15x15 maze from a seeded 16-bit LFSR and streams it out one bit per cycle.
// It then checks the solver's coordinate path, or its unsolvable verdict, against the
// transmitted maze.
//
// Optional feature macro: MAZE_STREAM_HOST_CHECK_EN. When it is defined, the stored map
// and the path checks (errors 1-4 and 6) are built in. Without it, only the timeout
// error (5) and the protocol error (7) are raised. The transmitted stream is the same
// in both builds.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start, seed             begin a run (sampled only in IDLE), LFSR seed (0 = SEED_DEFAULT)
//   maze, in_valid          serial maze bit (1 = wall) and its qualifier
//   out_valid, out_x, out_y solver path beat and its column/row
//   maze_not_valid          solver verdict: maze is unsolvable
//   busy, done              run in progress, one-cycle end-of-run pulse
//   pass, unsolvable        run result; held until the next start
//   err_code, path_len      first error seen, path beats received (saturates at 255)
module maze_stream_host #(
   parameter logic [15:0] SEED_DEFAULT = 16'hACE1,
   parameter int unsigned TIMEOUT      = 4095
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] seed,
   output logic        maze,
   output logic        in_valid,
   input  logic        out_valid,
   input  logic        maze_not_valid,
   input  logic [3:0]  out_x,
   input  logic [3:0]  out_y,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        unsolvable,
   output logic [2:0]  err_code,
   output logic [7:0]  path_len
);

   localparam int unsigned     CntW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);
   localparam logic [7:0]      LastIdx = 8'd224;

   typedef enum logic [2:0] {StIdle, StTx, StWait, StPath, StFin} state_e;

   state_e            state_q, state_d;
   logic [15:0]       lfsr_q, lfsr_d;
   logic [3:0]        x_q, x_d, y_q, y_d;
   logic [7:0]        idx_q, idx_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              pass_q, pass_d, unsolv_q, unsolv_d;
   logic [2:0]        err_q, err_d, err_new;
   logic [7:0]        len_q, len_d, len_inc;
   logic              lfsr_fb, cell_border, cell_special, cell_interior, cell_bit;

   assign lfsr_fb       = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
   assign cell_border   = (x_q == 4'd0) || (x_q == 4'd14) || (y_q == 4'd0) || (y_q == 4'd14);
   assign cell_special  = ((x_q == 4'd1) && (y_q == 4'd1)) || ((x_q == 4'd13) && (y_q == 4'd13));
   assign cell_interior = !cell_border && !cell_special;
   // Only interior non-special cells consume LFSR state.
   assign cell_bit      = cell_border || (cell_interior && (lfsr_q[1:0] == 2'b00));
   assign len_inc       = (len_q == 8'hFF) ? 8'hFF : len_q + 8'd1;

`ifdef MAZE_STREAM_HOST_CHECK_EN
   logic [224:0] map_q, map_d;
   logic [3:0]   px_q, px_d, py_q, py_d;
   logic [7:0]   beat_idx;
   logic [3:0]   dx, dy;
   logic [4:0]   dist;
   logic         beat_wall, beat_first_bad, beat_not_adj, end_bad;

   always_comb begin
      beat_idx       = 8'(out_y) * 8'd15 + 8'(out_x);
      dx             = (out_x > px_q) ? out_x - px_q : px_q - out_x;
      dy             = (out_y > py_q) ? out_y - py_q : py_q - out_y;
      dist           = {1'b0, dx} + {1'b0, dy};
      beat_not_adj   = (dist != 5'd1);
      // Off-grid coordinates count as walls; the map is only read for on-grid ones.
      beat_wall      = ((out_x > 4'd14) || (out_y > 4'd14)) ? 1'b1 : map_q[beat_idx];
      beat_first_bad = (out_x != 4'd1) || (out_y != 4'd1);
      end_bad        = (px_q != 4'd13) || (py_q != 4'd13);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         map_q <= '0;
         px_q  <= '0;
         py_q  <= '0;
      end else begin
         map_q <= map_d;
         px_q  <= px_d;
         py_q  <= py_d;
      end
   end
`else
   logic unused_coord;
   assign unused_coord = ^{out_x, out_y};
`endif

   always_comb begin
      state_d  = state_q;
      lfsr_d   = lfsr_q;
      x_d      = x_q;
      y_d      = y_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      pass_d   = pass_q;
      unsolv_d = unsolv_q;
      err_d    = err_q;
      len_d    = len_q;
      err_new  = 3'd0;
`ifdef MAZE_STREAM_HOST_CHECK_EN
      map_d    = map_q;
      px_d     = px_q;
      py_d     = py_q;
`endif
      // Error candidates are assigned highest code first so the lowest code on a
      // beat wins.
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d  = StTx;
               lfsr_d   = (seed == 16'd0) ? SEED_DEFAULT : seed;
               x_d      = '0;
               y_d      = '0;
               idx_d    = '0;
               pass_d   = 1'b0;
               unsolv_d = 1'b0;
               err_d    = 3'd0;
               len_d    = 8'd0;
            end
         end
         StTx: begin
            if (cell_interior) lfsr_d = {lfsr_q[14:0], lfsr_fb};
`ifdef MAZE_STREAM_HOST_CHECK_EN
            map_d[idx_q] = cell_bit;
`endif
            idx_d = idx_q + 8'd1;
            if (x_q == 4'd14) begin
               x_d = '0;
               y_d = y_q + 4'd1;
            end else begin
               x_d = x_q + 4'd1;
            end
            if (idx_q == LastIdx) begin
               state_d = StWait;
               cnt_d   = '0;
            end
         end
         StWait: begin
            cnt_d = cnt_q + CntW'(1);
            if (out_valid && maze_not_valid) begin
               err_new = 3'd7;
               len_d   = len_inc;
               state_d = StFin;
            end else if (maze_not_valid) begin
               unsolv_d = 1'b1;
               state_d  = StFin;
            end else if (out_valid) begin
               len_d   = len_inc;
               state_d = StPath;
`ifdef MAZE_STREAM_HOST_CHECK_EN
               px_d    = out_x;
               py_d    = out_y;
               if (beat_wall) err_new = 3'd3;
               if (beat_first_bad) err_new = 3'd1;
`endif
            end else if (cnt_q == CntMax) begin
               err_new = 3'd5;
               state_d = StFin;
            end
         end
         StPath: begin
            if (maze_not_valid) err_new = 3'd7;
            if (out_valid) begin
               len_d = len_inc;
`ifdef MAZE_STREAM_HOST_CHECK_EN
               px_d  = out_x;
               py_d  = out_y;
               if (len_q >= 8'd225) err_new = 3'd6;
               if (beat_wall) err_new = 3'd3;
               if (beat_not_adj) err_new = 3'd2;
`endif
            end else begin
`ifdef MAZE_STREAM_HOST_CHECK_EN
               if (end_bad) err_new = 3'd4;
`endif
               state_d = StFin;
            end
         end
         StFin: state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (err_q == 3'd0 && err_new != 3'd0) err_d = err_new;
      if (state_d == StFin) pass_d = (err_d == 3'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         lfsr_q   <= '0;
         x_q      <= '0;
         y_q      <= '0;
         idx_q    <= '0;
         cnt_q    <= '0;
         pass_q   <= 1'b0;
         unsolv_q <= 1'b0;
         err_q    <= 3'd0;
         len_q    <= 8'd0;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         x_q      <= x_d;
         y_q      <= y_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         pass_q   <= pass_d;
         unsolv_q <= unsolv_d;
         err_q    <= err_d;
         len_q    <= len_d;
      end
   end

   assign in_valid   = (state_q == StTx);
   assign maze       = in_valid & cell_bit;
   assign busy       = (state_q == StTx) || (state_q == StWait) || (state_q == StPath);
   assign done       = (state_q == StFin);
   assign pass       = pass_q;
   assign unsolvable = unsolv_q;
   assign err_code   = err_q;
   assign path_len   = len_q;

endmodule

// File: doc/maze_stream_host.md
# maze_stream_host

Transmit-side counterpart of the maze solver. Generates a 15×15 maze from a seeded LFSR and streams it serially on `maze`/`in_valid`. It then consumes the solver's response (a coordinate path on `out_x`/`out_y`/`out_valid`, or a `maze_not_valid` pulse) and checks that response against the stored maze. It is the source and scoreboard used in front of the solver in system tests.

## Interface
- `SEED_DEFAULT`, default 16'hACE1: LFSR value used when `seed` is 0.
- `TIMEOUT`, default 4095: maximum number of WAIT cycles before a timeout error.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset. Asynchronous and active-low.
- `start` in 1: begin a run. Sampled only in IDLE.
- `seed` in 16: LFSR seed. Sampled with `start`.
- `maze` out 1: serial maze bit. 1 = wall.
- `in_valid` out 1: qualifies `maze`.
- `out_valid` in 1: solver path coordinate valid.
- `maze_not_valid` in 1: solver verdict that the maze is unsolvable.
- `out_x` in 4: path column.
- `out_y` in 4: path row.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse when a run finishes.
- `pass` out 1: result of the run, valid with `done` and held until the next `start`.
- `unsolvable` out 1: solver reported `maze_not_valid`. Held like `pass`.
- `err_code` out 3: first error seen. Held like `pass`.
- `path_len` out 8: number of `out_valid` beats received, saturating at 255.

## Operation
- Reset value of every output is 0.
- Cell indexing:
  - Stream index i = y*15 + x, for x, y in 0..14.
  - Index 0 (row 0, column 0) is sent first.
  - Stream length is exactly 225 bits.
- Maze content:
  - Border cells (x or y equal to 0 or 14) are 1.
  - Cells (1,1) and (13,13) are 0.
  - Every other cell is 1 iff `lfsr[1:0]==2'b00`. The LFSR advances one step after each such cell, and only then.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Shift left; the feedback bit enters at bit 0.
  - Loaded with `seed` on start, or with `SEED_DEFAULT` if `seed==0`.
- Each transmitted bit is also written into a 225-bit map register for checking.
- States:
  - IDLE: on `start`, go to TX.
  - TX: 225 cycles with `in_valid`=1; bit index counts 0..224. Then go to WAIT.
  - WAIT:
    - `maze_not_valid` → FIN with `unsolvable`=1.
    - `out_valid` → PATH; this beat is checked as the first coordinate.
    - Counter reaches `TIMEOUT` → FIN with err 5.
  - PATH: each `out_valid` beat is checked. `out_valid`=0 ends the path: check the last coordinate, then go to FIN.
  - FIN: `done`=1 for one cycle, `pass` = (err_code==0), then go to IDLE.
- Error codes (the first one is latched; later beats are still counted):
  - 1: first coordinate is not (1,1).
  - 2: step is not 4-adjacent to the previous coordinate (|dx|+|dy| must equal 1).
  - 3: coordinate is a wall, or x or y is greater than 14.
  - 4: last coordinate is not (13,13).
  - 5: timeout.
  - 6: more than 225 beats.
  - 7: `out_valid` and `maze_not_valid` high in the same cycle, or `maze_not_valid` seen in PATH.
- Error 7 behaviour:
  - In WAIT, simultaneous `out_valid` and `maze_not_valid` → FIN.
  - In PATH, error 7 is latched and PATH continues until `out_valid` drops.
- `start` while `busy` is ignored. Solver inputs in IDLE or TX are ignored.
- Reset mid-run: all state clears asynchronously and `in_valid` drops immediately. There is no partial-run report.

## Timing
- `start` accepted at edge N:
  - `busy` and `in_valid` are high from N+1.
  - Bit 0 is valid at N+1; bit 224 is valid at N+225.
  - WAIT is entered at N+226.
- `in_valid` is never deasserted mid-stream except by reset.
- `done` is asserted the cycle after the terminating event:
  - the `maze_not_valid` beat,
  - the first cycle with `out_valid` low,
  - or timeout.
- `busy` falls together with `done`. A new `start` is accepted the following cycle.
- `path_len` increments on every `out_valid` beat in WAIT and PATH.

## Configuration
- Macro `MAZE_STREAM_HOST_CHECK_EN`.
- Defined: all path checks (errors 1–4 and 6) are active, and the map register is instantiated.
- Undefined:
  - The map register and the adjacency and wall logic are omitted.
  - Only errors 5 and 7 are raised.
  - `path_len` is still counted.
  - The transmitted stream is identical in both builds.

## Test plan
- Seed 0, `start`:
  - Exactly 225 `in_valid` cycles.
  - Bits 0–15 are 1 and bit 16 (cell 1,1) is 0.
  - Bit 208 (cell 13,13) is 0 and bits 209–224 are 1.
  - A second `start` during TX is ignored.
- After TX, pulse `maze_not_valid` → `done` with `pass`=1, `unsolvable`=1, `path_len`=0.
- Feed a straight path of wall-free cells computed from the bench's LFSR model, ending at (13,13) → `pass`=1, `err_code`=0, `path_len` equal to the beat count.
- Feed (1,1),(1,3) → `err_code`=2. Feed (2,1) first → `err_code`=1. Feed a path through a known wall → `err_code`=3 (only with the macro defined).
- No solver response → `done` 4096 cycles after WAIT entry, with `err_code`=5 and `pass`=0.
- Assert `rst_n` low at TX bit 100 → `in_valid`=0 immediately, then a clean 225-bit run on the next `start`.
